// File: rtl/spi_reg_slave_pkg.sv
// ============================================================================
// Module   : spi_slave_pkg
// Brief    : Shared constants and FSM state encodings for spi_reg_slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_slave_pkg;

    localparam logic [5:0] ADDR_WHO_AM_I  = 6'h0F;
    localparam logic [5:0] ADDR_CTRL_REG4 = 6'h23;
    localparam int         SIM_BIT        = 0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

endpackage

`default_nettype wire

// File: rtl/spi_reg_slave_if.sv
// ============================================================================
// Module   : spi_reg_slave_if
// Brief    : SPI pin bundle plus local register-write report port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_reg_slave_if;
    logic       spi_csn;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       reg_wr;
    logic [5:0] reg_addr;
    logic [7:0] reg_wdata;

    modport slave (
        input  spi_csn, spi_sck, spi_mosi,
        output spi_miso, spi_miso_oe, reg_wr, reg_addr, reg_wdata
    );

    modport master (
        output spi_csn, spi_sck, spi_mosi,
        input  spi_miso, spi_miso_oe, reg_wr, reg_addr, reg_wdata
    );
endinterface

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// Module   : spi_sync_edge
// Brief    : 2-FF synchronizer with rise/fall detection on the synced value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk_in,
    input  wire logic nrst,
    input  wire logic i_din,
    output logic      o_sync,
    output logic      o_rise,
    output logic      o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_reg_slave.sv
// ============================================================================
// Module   : spi_reg_slave
// Brief    : Oversampled SPI mode-3 slave serving a 64x8 register file.
//            Define SPI_SLAVE_3WIRE_EN to honour the CTRL_REG4 SIM bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_reg_slave
    import spi_slave_pkg::*;
#(
    parameter logic [7:0] WHOAMI = 8'h33
) (
    input  wire logic       clk_in,
    input  wire logic       nrst,
    spi_reg_slave_if.slave  bus
);

    logic       w_csn_sync, w_csn_rise, w_csn_fall;
    logic       w_sck_sync, w_sck_rise, w_sck_fall;
    logic       w_mosi, w_mosi_rise, w_mosi_fall;
    logic       w_unused;

    logic [1:0] r_state, w_state_nxt;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx;
    logic [7:0] r_tx;
    logic       r_rw, r_ms, r_miso;
    logic [5:0] r_addr;
    logic       r_wr_pend;
    logic [5:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic       r_reg_wr;
    logic [5:0] r_reg_addr;
    logic [7:0] r_reg_wdata;
    logic [7:0] r_regs [0:63];
    logic [7:0] w_rd;
    logic       w_mosi_bit;
    logic [7:0] w_byte;
    logic       w_last_bit;

    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_csn (
        .clk_in(clk_in), .nrst(nrst), .i_din(bus.spi_csn),
        .o_sync(w_csn_sync), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_sck (
        .clk_in(clk_in), .nrst(nrst), .i_din(bus.spi_sck),
        .o_sync(w_sck_sync), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk_in(clk_in), .nrst(nrst), .i_din(bus.spi_mosi),
        .o_sync(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = w_csn_sync ^ w_sck_sync ^ w_mosi_rise ^ w_mosi_fall;

`ifdef SPI_SLAVE_3WIRE_EN
    // SIM is sampled only while idle, so a new value never applies mid-frame.
    logic r_sim_active;
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst)
            r_sim_active <= 1'b0;
        else if (r_state == IDLE)
            r_sim_active <= r_regs[ADDR_CTRL_REG4][SIM_BIT];
    end
    // In 3-wire reads the shared line carries our own data; do not shift it in.
    assign w_mosi_bit = (r_sim_active && r_state == DATA && r_rw) ? 1'b0 : w_mosi;
`else
    assign w_mosi_bit = w_mosi;
`endif

    assign w_byte     = {r_rx, w_mosi_bit};
    assign w_last_bit = w_sck_rise && (r_bit_cnt == 3'd7) && (r_state != IDLE);
    assign w_rd       = (r_addr == ADDR_WHO_AM_I) ? WHOAMI : r_regs[r_addr];

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_csn_fall) w_state_nxt = CMD;
            CMD: begin
                if (w_csn_rise)
                    w_state_nxt = IDLE;
                else if (w_sck_rise && r_bit_cnt == 3'd7)
                    w_state_nxt = DATA;
            end
            DATA:    if (w_csn_rise) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A byte finishing together with CSN rise still raises r_wr_pend and commits.
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            r_bit_cnt   <= 3'd0;
            r_rx        <= 7'd0;
            r_tx        <= 8'd0;
            r_rw        <= 1'b0;
            r_ms        <= 1'b0;
            r_addr      <= 6'd0;
            r_miso      <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_wr_addr   <= 6'd0;
            r_wr_data   <= 8'd0;
            r_reg_wr    <= 1'b0;
            r_reg_addr  <= 6'd0;
            r_reg_wdata <= 8'd0;
        end else begin
            r_wr_pend <= 1'b0;
            if (r_state == IDLE || w_csn_rise)
                r_bit_cnt <= 3'd0;
            else if (w_sck_rise)
                r_bit_cnt <= r_bit_cnt + 3'd1;

            if (w_sck_rise && r_state != IDLE)
                r_rx <= w_byte[6:0];

            if (w_last_bit && r_state == CMD)
                {r_rw, r_ms, r_addr} <= w_byte;

            if (w_last_bit && r_state == DATA) begin
                if (!r_rw) begin
                    r_wr_pend <= 1'b1;
                    r_wr_addr <= r_addr;
                    r_wr_data <= w_byte;
                end
                if (r_ms)
                    r_addr <= r_addr + 6'd1;
            end

            if (w_sck_fall && r_state == DATA && r_rw && !w_csn_rise) begin
                if (r_bit_cnt == 3'd0) begin
                    r_miso <= w_rd[7];
                    r_tx   <= {w_rd[6:0], 1'b0};
                end else begin
                    r_miso <= r_tx[7];
                    r_tx   <= {r_tx[6:0], 1'b0};
                end
            end

            r_reg_wr <= r_wr_pend;
            if (r_wr_pend) begin
                r_reg_addr  <= r_wr_addr;
                r_reg_wdata <= r_wr_data;
            end
        end
    end

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 64; i++)
                r_regs[i] <= 8'h00;
        end else if (r_wr_pend && r_wr_addr != ADDR_WHO_AM_I) begin
            r_regs[r_wr_addr] <= r_wr_data;
        end
    end

    assign bus.spi_miso    = r_miso;
    assign bus.spi_miso_oe = (r_state == DATA) && r_rw;
    assign bus.reg_wr      = r_reg_wr;
    assign bus.reg_addr    = r_reg_addr;
    assign bus.reg_wdata   = r_reg_wdata;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
// ============================================================================
// Module   : tb_spi_reg_slave
// Brief    : Directed self-checking bench for spi_reg_slave (SPI mode 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_reg_slave;

    logic clk_in = 1'b0;
    logic nrst   = 1'b0;
    logic mosi_drv = 1'b0;
    logic three_wire = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise = 0;
    int wr_cnt = 0;
    int wr_lat = 0;
    logic [5:0] wr_addr = 6'd0;
    logic [7:0] wr_data = 8'd0;
    logic [31:0] rx;
    int base;

    spi_reg_slave_if bus ();

    assign bus.spi_mosi = (three_wire && bus.spi_miso_oe) ? bus.spi_miso : mosi_drv;

    spi_reg_slave #(.WHOAMI(8'h33)) dut (
        .clk_in(clk_in),
        .nrst  (nrst),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (bus.reg_wr === 1'b1) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = bus.reg_addr;
            wr_data = bus.reg_wdata;
            wr_lat  = cyc - last_rise;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cs_low();
        bus.spi_csn = 1'b0;
        tick(8);
    endtask

    task automatic cs_high();
        bus.spi_csn = 1'b1;
        tick(16);
    endtask

    // Shift nbits MSB first; read data is sampled just before each rising edge.
    task automatic xfer(input logic [31:0] tx, input int nbits, output logic [31:0] rxo);
        rxo = 32'd0;
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.spi_sck = 1'b0;
            mosi_drv = tx[i];
            tick(8);
            rxo = {rxo[30:0], (three_wire ? bus.spi_mosi : bus.spi_miso)};
            bus.spi_sck = 1'b1;
            last_rise = cyc;
            tick(8);
        end
    endtask

    task automatic frame(input logic [31:0] tx, input int nbits, output logic [31:0] rxo);
        cs_low();
        xfer(tx, nbits, rxo);
        tick(8);
        cs_high();
    endtask

    initial begin
        bus.spi_csn = 1'b1;
        bus.spi_sck = 1'b1;
        tick(3);
        check("rst_miso",  {31'd0, bus.spi_miso},    32'd0);
        check("rst_oe",    {31'd0, bus.spi_miso_oe}, 32'd0);
        check("rst_wr",    {31'd0, bus.reg_wr},      32'd0);
        check("rst_addr",  {26'd0, bus.reg_addr},    32'd0);
        check("rst_wdata", {24'd0, bus.reg_wdata},   32'd0);
        #2 nrst = 1'b1;
        tick(5);

        frame(32'h8F00, 16, rx);
        check("whoami_rd", rx & 32'hFF, 32'h33);
        check("whoami_nowr", wr_cnt, 0);

        frame(32'h2301, 16, rx);
        check("wr23_cnt",  wr_cnt, 1);
        check("wr23_addr", {26'd0, wr_addr}, 32'h23);
        check("wr23_data", {24'd0, wr_data}, 32'h01);
        check("wr23_lat",  wr_lat, 4);
        frame(32'hA300, 16, rx);
        check("rd23", rx & 32'hFF, 32'h01);

        frame(32'h7FAA55, 24, rx);
        check("burst_cnt",  wr_cnt, 3);
        check("burst_addr", {26'd0, wr_addr}, 32'h00);
        check("burst_data", {24'd0, wr_data}, 32'h55);
        frame(32'hFF0000, 24, rx);
        check("burst_rd3f", (rx >> 8) & 32'hFF, 32'hAA);
        check("burst_rd00", rx & 32'hFF, 32'h55);

        // Read aborted mid data byte: output enable must drop within 3 cycles.
        cs_low();
        xfer(32'h8F0, 12, rx);
        check("abort_oe_on", {31'd0, bus.spi_miso_oe}, 32'd1);
        bus.spi_csn = 1'b1;
        tick(3);
        check("abort_oe_off", {31'd0, bus.spi_miso_oe}, 32'd0);
        tick(16);

        cs_low();
        xfer(32'h10A, 12, rx);
        cs_high();
        check("abort_nowr", wr_cnt, 3);
        frame(32'h9000, 16, rx);
        check("abort_rd10", rx & 32'hFF, 32'h00);

        frame(32'h0F12, 16, rx);
        check("ro_cnt",  wr_cnt, 4);
        check("ro_addr", {26'd0, wr_addr}, 32'h0F);
        check("ro_data", {24'd0, wr_data}, 32'h12);
        frame(32'h8F00, 16, rx);
        check("ro_rd", rx & 32'hFF, 32'h33);

`ifdef SPI_SLAVE_3WIRE_EN
        frame(32'h2301, 16, rx);
        three_wire = 1'b1;
        frame(32'h8F00, 16, rx);
        check("3w_rd", rx & 32'hFF, 32'h33);
        frame(32'h2300, 16, rx);
        three_wire = 1'b0;
        frame(32'h8F00, 16, rx);
        check("4w_rd", rx & 32'hFF, 32'h33);
        frame(32'h2301, 16, rx);
`endif

        base = wr_cnt;
        #2 nrst = 1'b0;
        #1;
        check("rst2_addr",  {26'd0, bus.reg_addr},  32'd0);
        check("rst2_wdata", {24'd0, bus.reg_wdata}, 32'd0);
        tick(2);
        #2 nrst = 1'b1;
        tick(5);
        frame(32'hA300, 16, rx);
        check("rst2_rd23", rx & 32'hFF, 32'h00);
        check("rst2_nowr", wr_cnt, base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_reg_slave.md
# spi_reg_slave

Synthesizable SPI responder that lets the system act as an 8-bit register-mapped slave: the far end of the link driven by `spi_master`. All SPI pins are oversampled and decoded in the `clk_in` domain. The block decodes LIS3DH-style command bytes (R/W, auto-increment, 6-bit address) and serves a 64×8 register file with a read-only WHO_AM_I. Register writes are reported to local logic through a strobe.

## Interface
- `WHOAMI`, 8'h33: value returned at address 0x0F; writes to it are ignored.
- `clk_in`  in  1  system clock; only clock in the block.
- `nrst`  in  1  reset, asynchronous, active-low.
- `spi_csn`  in  1  chip select, active-low, asynchronous to `clk_in`.
- `spi_sck`  in  1  SPI clock, mode 3 (idles high), asynchronous.
- `spi_mosi`  in  1  serial data in; in 3-wire mode, the input side of the shared SDIO line.
- `spi_miso`  out  1  serial data out, MSB first.
- `spi_miso_oe`  out  1  output enable for `spi_miso` (4-wire) or for the shared SDIO line (3-wire); the top level instantiates the tristate.
- `reg_wr`  out  1  one-cycle pulse per committed write.
- `reg_addr`  out  6  address of the write.
- `reg_wdata`  out  8  data of the write.

## Operation
- Input conditioning: each SPI input passes through a 2-FF synchronizer. Rising and falling SCK edges are detected on the synchronized value.
- FSM states:
  - IDLE: CSN high.
  - CMD: shifting the command byte.
  - DATA: shifting data bytes.
- FSM transitions:
  - IDLE→CMD on a synchronized CSN falling edge.
  - CMD→DATA after the 8th SCK rising edge.
  - Any state→IDLE on CSN rising.
- Command byte: bit7 = RW (1 = read), bit6 = MS (1 = auto-increment), bits5:0 = address.
- Sampling: MOSI is sampled on SCK rising; MISO is updated on SCK falling.
- Bit counter: 3 bits; it wraps every 8 bits, and each wrap ends a byte.
- Read:
  - The register at the current address is loaded into the shift register on the SCK falling edge after the command byte.
  - Each subsequent falling edge shifts out the next bit.
  - `spi_miso_oe` = 1 during DATA when RW = 1, and 0 otherwise.
- Write: on the 8th rising edge of each data byte, the register is updated (unless the address is 0x0F) and `reg_wr` pulses once.
- Auto-increment:
  - After each complete data byte, the address increments if MS = 1 and is held otherwise.
  - The address wraps from 0x3F to 0x00.
- Register file reset values: all 0x00, except 0x0F, which always reads `WHOAMI`.
- CTRL_REG4 (0x23), bit0 = SIM. The programmed value takes effect at the next CSN rising edge, never mid-frame.
- Abort: CSN rising mid-byte discards the partial byte (no write and no strobe), releases `spi_miso_oe`, and returns the FSM to IDLE.
- Simultaneous CSN rising and an 8th SCK rising in the same `clk_in` cycle: the byte completes and commits, then the FSM enters IDLE.
- Reset while asserted: all state, registers and outputs return to their reset values immediately.

## Timing
- Output reset values: `spi_miso` = 0, `spi_miso_oe` = 0, `reg_wr` = 0, `reg_addr` = 0, `reg_wdata` = 0.
- Latency from SPI pin edge to internal action: 3 `clk_in` cycles (2 synchronizer cycles plus 1 edge-detect cycle).
- `spi_miso` changes 3 cycles after SCK falls. `reg_wr` asserts 4 cycles after the 8th SCK rise of a write byte.
- Requirement on the master: SCK high time and SCK low time each ≥ 4 `clk_in` periods; CSN setup and hold to SCK ≥ 4 periods.
- This requirement is met by `spi_master` with `DIV_COEF` ≥ 1. With `DIV_COEF` = 0, `spi_master` is out of contract for this block.

## Configuration
- `SPI_SLAVE_3WIRE_EN` defined:
  - The SIM bit is honoured.
  - When SIM = 1, read data is driven on the shared SDIO line: the block asserts `spi_miso_oe` during the DATA read phase, and the top level muxes `spi_miso` onto the MOSI pad.
  - The command byte and write data are still taken from `spi_mosi`.
- `SPI_SLAVE_3WIRE_EN` undefined:
  - SIM is storage only.
  - The block always operates 4-wire.
  - The 3-wire mux logic is not generated.

## Structure
- Shared package `spi_slave_pkg` holds:
  - address constants: `ADDR_WHO_AM_I` = 6'h0F, `ADDR_CTRL_REG4` = 6'h23;
  - `SIM_BIT` = 0;
  - FSM state encodings: IDLE, CMD, DATA.
- Sub-module `spi_sync_edge`: 2-FF synchronizer plus rise/fall detect, instantiated once per input (CSN, SCK, MOSI).

## Test plan
- WHO_AM_I read: 16-bit frame 0x8F00 → `miso_data[7:0]` = 0x33; no `reg_wr` pulse.
- Write then read back: frame 0x2301 → one `reg_wr` pulse with addr 0x23, data 0x01. Then frame 0xA300 → 0x01.
- Burst with wrap: 24-bit write frame 0x7FAA55 → regs 0x3F = 0xAA and 0x00 = 0x55. A read with MS = 1 (0xFF) returns 0xAA, then 0x55.
- Abort: CSN raised after 4 bits of a write data byte → register unchanged, no `reg_wr` pulse, `spi_miso_oe` = 0 within 3 cycles.
- Write to read-only address: frame 0x0F12 → no change (a subsequent read of 0x0F still returns 0x33); `reg_wr` still pulses.
- 3-wire (`SPI_SLAVE_3WIRE_EN`):
  - Write 0x2301, then switch the master to 3-wire.
  - A WHO_AM_I read returns 0x33 via SDIO.
  - Write 0x2300, then switch the master back to 4-wire.
  - A further read returns 0x33 on `spi_miso`.
